mod3_poly_sched: RTL and testbench
==================================

// Module: mod3_poly_sched
// PURPOSE
//  Sequences reduction of a byte-coefficient polynomial mod 3 for the ternary path.
//  Fetches N_COEF bytes from a sync-read coefficient RAM and runs each through a
//  2-bit/cycle serial mod-3 reducer. Emits one trit per coefficient on a valid/ready stream.
//  Sits between the coefficient buffer and the trit packer of the HRSS sampler.
// PARAMETERS
//  N_COEF  701  coefficients per run (>=1)
//  ADDR_W  10   RAM address width; also width of the coefficient index
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       begin a run; sampled only in IDLE
//  base_addr  in   ADDR_W  RAM address of coefficient 0; latched on accepted start
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse after the last trit is accepted
//  rd_en      out  1       RAM read strobe
//  rd_addr    out  ADDR_W  RAM read address
//  rd_data    in   8       RAM data; valid the cycle after rd_en
//  out_valid  out  1       trit available
//  out_ready  in   1       consumer accepts when out_valid&&out_ready
//  out_trit   out  2       residue: 00=0, 01=1, 11=2 (10 never driven)
//  out_idx    out  ADDR_W  coefficient index of out_trit (0..N_COEF-1)
// BEHAVIOUR
//  Reset: FSM=IDLE; busy, done, rd_en, out_valid=0; rd_addr, out_trit, out_idx=0; idx=0.
//  FSM IDLE->FETCH->LOAD->REDUCE(x4)->EMIT->{FETCH|DONE}; DONE->IDLE.
//   IDLE: start=1 -> latch base_addr, idx=0, busy=1, go FETCH. Otherwise stay.
//   FETCH (1 cyc): rd_en=1, rd_addr=base+idx, sum mod 2^ADDR_W (wraps).
//   LOAD (1 cyc): capture rd_data into reducer shift reg; residue state=0.
//   REDUCE (4 cyc): per cycle consume low 2 bits, shift right 2; residue update:
//    digit 00/11 -> unchanged; 01 -> +1 mod 3; 10 -> +2 mod 3.
//   EMIT: out_valid=1, out_trit=residue, out_idx=idx; all stable until handshake.
//    On handshake: idx==N_COEF-1 -> DONE, else idx+1 and FETCH.
//   DONE (1 cyc): done=1, busy=0; then IDLE.
//  Latency: 7 cycles start->first out_valid; 7 cycles per coefficient at out_ready=1.
//  rd_en is 0 outside FETCH. out_valid is 0 outside EMIT.
//  start while busy: ignored; no restart, base_addr not re-latched.
//  start in DONE cycle: ignored; accepted from the following IDLE cycle.
//  out_ready held low: FSM stalls in EMIT indefinitely; no further RAM reads.
//  rst mid-run: immediate return to reset values; partial run discarded, no done.
//  N_COEF=1: single coefficient, DONE after its handshake.
// STRUCTURE
//  Package ternary_pkg: trit_t (2-bit), TRIT_0=2'b00, TRIT_1=2'b01, TRIT_2=2'b11;
//   sched_state_t enum {IDLE,FETCH,LOAD,REDUCE,EMIT,DONE}.
//  Sub-module mod3_byte_serial: load, shift_en, din[7:0] -> residue (trit_t). Clears on load.
//   Advances only on shift_en. Owned 4-cycle counter stays in scheduler.
//  Scheduler holds FSM, idx counter, base register, 2-bit REDUCE counter.
// TESTING
//  1 RAM[0..3]=FF,07,05,00, base=0, N=4, out_ready=1 -> trits 00,01,11,00 idx 0..3.
//    First out_valid 7 cyc after start. done pulses once, busy falls with it.
//  2 Backpressure: out_ready low 3 cyc in EMIT of idx1 -> out_valid/trit/idx stable.
//    rd_en stays 0; run resumes on handshake with correct results.
//  3 base=0x3FE, N=4, ADDR_W=10 -> rd_addr sequence 3FE,3FF,000,001.
//  4 start pulsed at idx2 of run -> ignored; exactly N trits and one done.
//  5 rst asserted in REDUCE of idx1 -> next cycle all outputs 0, IDLE.
//    New start runs cleanly from idx0.
//  6 Exhaustive 0x00..0xFF, N=256 -> each out_trit == encode(byte%3).
//    rd_data is RAM[base+idx], checked per coefficient.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared types for the ternary sampling path:
// trit encoding, scheduler states and mod-3 digit accumulate.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0 = 2'b00;
  localparam trit_t TRIT_1 = 2'b01;
  localparam trit_t TRIT_2 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    REDUCE,
    EMIT,
    DONE
  } sched_state_t;

  // A base-4 digit weighs 1 mod 3, so digits just add.
  function automatic trit_t trit_add(trit_t r, logic [1:0] d);
    logic [1:0] rv;
    logic [1:0] dv;
    logic [2:0] s;
    rv = r[1] ? 2'd2 : {1'b0, r[0]};
    dv = (d == 2'd3) ? 2'd0 : d;
    s  = {1'b0, rv} + {1'b0, dv};
    if (s >= 3'd3) s = s - 3'd3;
    case (s[1:0])
      2'd1:    return TRIT_1;
      2'd2:    return TRIT_2;
      default: return TRIT_0;
    endcase
  endfunction

endpackage

// File: rtl/mod3_poly_sched_if.sv
// Control, RAM read port and trit stream of the
// mod-3 scheduler; master is the scheduler side.
interface mod3_poly_sched_if #(
  parameter int ADDR_W = 10
);
  import ternary_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              out_valid;
  logic              out_ready;
  trit_t             out_trit;
  logic [ADDR_W-1:0] out_idx;

  modport master (
    input  start, base_addr, rd_data, out_ready,
    output busy, done, rd_en, rd_addr,
    output out_valid, out_trit, out_idx
  );

  modport slave (
    output start, base_addr, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr,
    input  out_valid, out_trit, out_idx
  );

endinterface

// File: rtl/mod3_byte_serial.sv
// Serial mod-3 reducer: consumes a byte two bits
// per shift_en, low digit first.
module mod3_byte_serial
  import ternary_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       shift_en_i,
  input  logic [7:0] din_i,
  output trit_t      residue_o
);

  logic [7:0] sh_q, sh_d;
  trit_t      res_q, res_d;

  always_comb begin
    sh_d  = sh_q;
    res_d = res_q;
    if (load_i) begin
      sh_d  = din_i;
      res_d = TRIT_0;
    end else if (shift_en_i) begin
      sh_d  = {2'b00, sh_q[7:2]};
      res_d = trit_add(res_q, sh_q[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      res_q <= TRIT_0;
    end else begin
      sh_q  <= sh_d;
      res_q <= res_d;
    end
  end

  assign residue_o = res_q;

endmodule

// File: rtl/mod3_poly_sched.sv
// Walks N_COEF coefficient bytes from RAM and
// streams one mod-3 trit per coefficient.
module mod3_poly_sched
  import ternary_pkg::*;
#(
  parameter int N_COEF = 701,
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  mod3_poly_sched_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_COEF - 1);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        cnt_q, cnt_d;
  trit_t             residue;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = REDUCE;
      end
      REDUCE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  mod3_byte_serial u_red (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == LOAD),
    .shift_en_i (state_q == REDUCE),
    .din_i      (bus.rd_data),
    .residue_o  (residue)
  );

  // Outputs are gated so idle values read as zero.
  assign bus.rd_en     = (state_q == FETCH);
  assign bus.rd_addr   = bus.rd_en ? base_q + idx_q : '0;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_trit  = bus.out_valid ? residue : TRIT_0;
  assign bus.out_idx   = bus.out_valid ? idx_q : '0;
  assign bus.busy      = (state_q != IDLE) &&
                         (state_q != DONE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_mod3_poly_sched.sv
// Directed bench for mod3_poly_sched: an N=4 instance
// for sequencing cases, an N=256 instance for all bytes.
module tb_mod3_poly_sched;
  import ternary_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod3_poly_sched_if #(.ADDR_W(AW)) ia ();
  mod3_poly_sched_if #(.ADDR_W(AW)) ib ();

  mod3_poly_sched #(.N_COEF(4), .ADDR_W(AW)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  mod3_poly_sched #(.N_COEF(256), .ADDR_W(AW)) u_dut256 (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (ia.rd_en) ia.rd_data <= mem[ia.rd_addr];
    if (ib.rd_en) ib.rd_data <= mem[ib.rd_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  trit_t         qt_a[$];
  logic [AW-1:0] qi_a[$];
  logic [AW-1:0] qr_a[$];
  int            nd_a;
  bit            bd_a;
  trit_t         qt_b[$];
  logic [AW-1:0] qi_b[$];
  logic [AW-1:0] qr_b[$];
  int            nd_b;

  trit_t exp1 [4] = '{2'b00, 2'b01, 2'b11, 2'b00};

  function automatic trit_t enc(int v);
    case (v % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Record what the coming edge will see, then advance.
  task automatic tick();
    if (ia.out_valid && ia.out_ready) begin
      qt_a.push_back(ia.out_trit);
      qi_a.push_back(ia.out_idx);
    end
    if (ia.rd_en) qr_a.push_back(ia.rd_addr);
    if (ia.done) begin
      nd_a++;
      if (ia.busy) bd_a = 1'b1;
    end
    if (ib.out_valid && ib.out_ready) begin
      qt_b.push_back(ib.out_trit);
      qi_b.push_back(ib.out_idx);
    end
    if (ib.rd_en) qr_b.push_back(ib.rd_addr);
    if (ib.done) nd_b++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    qt_a.delete(); qi_a.delete(); qr_a.delete();
    qt_b.delete(); qi_b.delete(); qr_b.delete();
    nd_a = 0; bd_a = 1'b0; nd_b = 0;
  endtask

  task automatic start_a(input logic [AW-1:0] base);
    ia.base_addr = base;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({ia.busy, ia.done, ia.rd_en, ia.out_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0000",
        {ia.busy, ia.done, ia.rd_en, ia.out_valid});
    end
    n_chk++;
    if ({ia.rd_addr, ia.out_trit, ia.out_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%b/%h want 0",
        ia.rd_addr, ia.out_trit, ia.out_idx);
    end
    n_chk++;
    if ({ib.busy, ib.done, ib.rd_en, ib.out_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl_b got %b want 0000",
        {ib.busy, ib.done, ib.rd_en, ib.out_valid});
    end
    rst = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (ia.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy got %b want 0", ia.busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    mem[0] = 8'hFF; mem[1] = 8'h07;
    mem[2] = 8'h05; mem[3] = 8'h00;
    clear_mon();
    ia.out_ready = 1'b1;
    start_a(10'h000);
    n_chk++;
    if (ia.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on_start got %b want 1", ia.busy);
    end
    lat = 1;
    while (!ia.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_chk++;
    if (lat != 7) begin
      n_fail++;
      $display("FAIL first_latency got %0d want 7", lat);
    end
    repeat (40) tick();
    n_chk++;
    if (qt_a.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 4", qt_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < qt_a.size()) begin
        n_chk++;
        if (qt_a[i] !== exp1[i] || qi_a[i] !== AW'(i)) begin
          n_fail++;
          $display("FAIL basic_trit%0d got %b@%0d want %b@%0d",
            i, qt_a[i], qi_a[i], exp1[i], i);
        end
      end
    end
    n_chk++;
    if (nd_a != 1 || bd_a) begin
      n_fail++;
      $display("FAIL basic_done got %0d pulses busy_overlap=%b want 1/0",
        nd_a, bd_a);
    end
    n_chk++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end got busy=%b done=%b want 0/0",
        ia.busy, ia.done);
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_mon();
    ia.out_ready = 1'b1;
    start_a(10'h000);
    n = 0;
    while (!(ia.out_valid && ia.out_idx == 10'd1) && n < 30) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= 30) begin
      n_fail++;
      $display("FAIL bp_wait got timeout want EMIT idx1");
    end
    ia.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (ia.out_valid !== 1'b1 || ia.out_trit !== 2'b01 ||
          ia.out_idx !== 10'd1 || ia.rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d got v=%b t=%b i=%0d rd=%b want 1/01/1/0",
          k, ia.out_valid, ia.out_trit, ia.out_idx, ia.rd_en);
      end
    end
    ia.out_ready = 1'b1;
    repeat (30) tick();
    n_chk++;
    if (qt_a.size() != 4 || qr_a.size() != 4 || nd_a != 1) begin
      n_fail++;
      $display("FAIL bp_counts got %0d/%0d/%0d want 4/4/1",
        qt_a.size(), qr_a.size(), nd_a);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < qt_a.size()) begin
        n_chk++;
        if (qt_a[i] !== exp1[i] || qi_a[i] !== AW'(i)) begin
          n_fail++;
          $display("FAIL bp_trit%0d got %b@%0d want %b@%0d",
            i, qt_a[i], qi_a[i], exp1[i], i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [4];
    trit_t         et [4];
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    et = '{2'b11, 2'b01, 2'b00, 2'b01};
    mem[10'h3FE] = 8'h02;
    mem[10'h3FF] = 8'h10;
    clear_mon();
    ia.out_ready = 1'b1;
    start_a(10'h3FE);
    repeat (40) tick();
    n_chk++;
    if (qr_a.size() != 4 || qt_a.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_counts got %0d/%0d want 4/4",
        qr_a.size(), qt_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < qr_a.size() && i < qt_a.size()) begin
        n_chk++;
        if (qr_a[i] !== ea[i] || qt_a[i] !== et[i]) begin
          n_fail++;
          $display("FAIL wrap%0d got %h/%b want %h/%b",
            i, qr_a[i], qt_a[i], ea[i], et[i]);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    int n;
    clear_mon();
    ia.out_ready = 1'b1;
    start_a(10'h000);
    n = 0;
    while (!(ia.out_valid && ia.out_idx == 10'd2) && n < 40) begin
      tick();
      n++;
    end
    ia.base_addr = 10'h100;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    repeat (30) tick();
    n_chk++;
    if (qt_a.size() != 4 || nd_a != 1 || qr_a.size() != 4) begin
      n_fail++;
      $display("FAIL sb_counts got %0d/%0d/%0d want 4/1/4",
        qt_a.size(), nd_a, qr_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < qr_a.size() && i < qt_a.size()) begin
        n_chk++;
        if (qr_a[i] !== AW'(i) || qt_a[i] !== exp1[i]) begin
          n_fail++;
          $display("FAIL sb%0d got %h/%b want %h/%b",
            i, qr_a[i], qt_a[i], i, exp1[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    clear_mon();
    ia.out_ready = 1'b1;
    start_a(10'h000);
    repeat (10) tick();
    n_chk++;
    if (ia.busy !== 1'b1 || ia.out_valid !== 1'b0 ||
        ia.rd_en !== 1'b0 || qt_a.size() != 1) begin
      n_fail++;
      $display("FAIL rm_pre got b=%b v=%b rd=%b n=%0d want 1/0/0/1",
        ia.busy, ia.out_valid, ia.rd_en, qt_a.size());
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({ia.busy, ia.done, ia.rd_en, ia.out_valid} !== 4'b0 ||
        {ia.rd_addr, ia.out_trit, ia.out_idx} !== '0) begin
      n_fail++;
      $display("FAIL rm_reset got %b %h/%b/%h want all 0",
        {ia.busy, ia.done, ia.rd_en, ia.out_valid},
        ia.rd_addr, ia.out_trit, ia.out_idx);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (nd_a != 0 || ia.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_nodone got %0d/%b want 0/0", nd_a, ia.busy);
    end
    clear_mon();
    start_a(10'h000);
    repeat (40) tick();
    n_chk++;
    if (qt_a.size() != 4 || nd_a != 1) begin
      n_fail++;
      $display("FAIL rm_rerun got %0d/%0d want 4/1",
        qt_a.size(), nd_a);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < qt_a.size()) begin
        n_chk++;
        if (qt_a[i] !== exp1[i] || qi_a[i] !== AW'(i)) begin
          n_fail++;
          $display("FAIL rm_trit%0d got %b@%0d want %b@%0d",
            i, qt_a[i], qi_a[i], exp1[i], i);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    int n;
    for (int i = 0; i < 256; i++) mem[256 + i] = 8'(i);
    clear_mon();
    ib.out_ready = 1'b1;
    ib.base_addr = 10'h100;
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    n = 0;
    while (nd_b == 0 && n < 2000) begin
      tick();
      n++;
    end
    n_chk++;
    if (nd_b != 1 || qt_b.size() != 256) begin
      n_fail++;
      $display("FAIL ex_counts got %0d done %0d trits want 1/256",
        nd_b, qt_b.size());
    end
    for (int i = 0; i < 256; i++) begin
      if (i < qt_b.size() && i < qr_b.size()) begin
        n_chk++;
        if (qt_b[i] !== enc(i) || qi_b[i] !== AW'(i) ||
            qr_b[i] !== AW'(256 + i)) begin
          n_fail++;
          $display("FAIL ex_byte%0d got %b@%0d a=%h want %b@%0d a=%h",
            i, qt_b[i], qi_b[i], qr_b[i], enc(i), i, 256 + i);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    ia.start = 1'b0; ia.base_addr = '0; ia.out_ready = 1'b1;
    ib.start = 1'b0; ib.base_addr = '0; ib.out_ready = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_busy();
    test_rst_mid();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
